// File: rtl/int_gateway_bank.sv
// Interrupt gateway bank: synchronizes raw interrupt wires, detects level/edge,
// and hands sources out through claim/complete. Optional macro: INT_GATEWAY_EDGE_CNT_EN.
module int_gateway_bank #(
  parameter int NUM_SRC     = 5,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic [NUM_SRC-1:0] int_in,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] src_enable,
  output logic               irq_out,
  input  logic               claim_req,
  output logic               claim_ack,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending_vec
);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] infl_q, infl_d;
  logic               irq_q, irq_d;
  logic               ack_q, ack_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] trig;
  logic [NUM_SRC-1:0] busy;
  logic [NUM_SRC-1:0] done;
  logic               win_found;
  logic [ID_W-1:0]    win_id;

`ifdef INT_GATEWAY_EDGE_CNT_EN
  logic [NUM_SRC-1:0][3:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0]      inc;
  logic [NUM_SRC-1:0]      dec;
`endif

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign trig = (edge_mode & rise) | (~edge_mode & sync);
  assign busy = pend_q | infl_q;

  // Shift the synchronizer chain and remember last synchronized value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], int_in};
    prev_d = sync;
  end

  // Lowest-index enabled pending source wins a claim
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && pend_q[i] && src_enable[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i + 1);
      end
    end
  end

  // Decode a completion that targets an in-flight source
  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      done[i] = complete_valid && infl_q[i] &&
                (complete_id == ID_W'(i + 1));
    end
  end

`ifdef INT_GATEWAY_EDGE_CNT_EN
  // Count edges that arrive while busy; replay one per completion
  always_comb begin
    cnt_d = cnt_q;
    inc   = '0;
    dec   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dec[i] = done[i] && edge_mode[i] && (cnt_q[i] != 4'd0);
      inc[i] = edge_mode[i] && rise[i] && busy[i] &&
               ((cnt_q[i] != 4'd15) || dec[i]);
      cnt_d[i] = cnt_q[i] + {3'b000, inc[i]} - {3'b000, dec[i]};
    end
  end
`endif

  // Pending/in-flight update; a claim overrides a same-cycle set
  always_comb begin
    pend_d = pend_q;
    infl_d = infl_q;
    irq_d  = |(pend_q & src_enable);
    ack_d  = claim_req;
    id_d   = claim_req ? win_id : '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (trig[i] && !busy[i]) pend_d[i] = 1'b1;
`ifdef INT_GATEWAY_EDGE_CNT_EN
      if (dec[i]) pend_d[i] = 1'b1;
`endif
      if (done[i]) infl_d[i] = 1'b0;
      if (claim_req && win_found && (win_id == ID_W'(i + 1))) begin
        pend_d[i] = 1'b0;
        infl_d[i] = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      infl_q <= '0;
      irq_q  <= 1'b0;
      ack_q  <= 1'b0;
      id_q   <= '0;
`ifdef INT_GATEWAY_EDGE_CNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      infl_q <= infl_d;
      irq_q  <= irq_d;
      ack_q  <= ack_d;
      id_q   <= id_d;
`ifdef INT_GATEWAY_EDGE_CNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign irq_out     = irq_q;
  assign claim_ack   = ack_q;
  assign claim_id    = id_q;
  assign pending_vec = pend_q;

endmodule

// File: tb/tb_int_gateway_bank.sv
// Testbench for int_gateway_bank: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_int_gateway_bank;

  localparam int N  = 5;
  localparam int S  = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rstnn = 1'b0;
  logic [N-1:0]  int_in = '0;
  logic [N-1:0]  edge_mode = '0;
  logic [N-1:0]  src_enable = '1;
  logic          irq_out;
  logic          claim_req = 1'b0;
  logic          claim_ack;
  logic [IW-1:0] claim_id;
  logic          complete_valid = 1'b0;
  logic [IW-1:0] complete_id = '0;
  logic [N-1:0]  pending_vec;

  int checks = 0;
  int errors = 0;

  int_gateway_bank #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rstnn(rstnn), .int_in(int_in),
    .edge_mode(edge_mode), .src_enable(src_enable),
    .irq_out(irq_out), .claim_req(claim_req),
    .claim_ack(claim_ack), .claim_id(claim_id),
    .complete_valid(complete_valid),
    .complete_id(complete_id), .pending_vec(pending_vec)
  );

  always #5 clk = ~clk;

  // Reference model: the wire value seen by detection is the one
  // captured S edges ago; per-source pending/in-flight bits as vectors.
  logic [N-1:0]  dl[$];
  logic [N-1:0]  m_pend, m_infl;
  logic          m_irq, m_ack;
  logic [IW-1:0] m_id;
  int            m_cnt[N];

  function automatic void m_reset();
    dl = {};
    for (int i = 0; i <= S; i++) dl.push_back('0);
    m_pend = '0; m_infl = '0;
    m_irq = 1'b0; m_ack = 1'b0; m_id = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic void m_tick();
    logic [N-1:0] sy, pv, np, ni;
    int w, k;
    bit rise, hit, busy, done;
    int inc, dec;
    sy = dl[S-1];
    pv = dl[S];
    w = -1;
    k = complete_valid ? int'(complete_id) : 0;
    for (int i = 0; i < N; i++)
      if (w < 0 && m_pend[i] && src_enable[i]) w = i;
    m_irq = |(m_pend & src_enable);
    m_ack = claim_req;
    m_id  = (claim_req && w >= 0) ? IW'(w + 1) : '0;
    np = m_pend;
    ni = m_infl;
    for (int i = 0; i < N; i++) begin
      rise = sy[i] && !pv[i];
      hit  = edge_mode[i] ? rise : sy[i];
      busy = m_pend[i] || m_infl[i];
      done = (k == i + 1) && m_infl[i];
      if (hit && !busy) np[i] = 1'b1;
`ifdef INT_GATEWAY_EDGE_CNT_EN
      inc = (edge_mode[i] && rise && busy) ? 1 : 0;
      dec = (done && edge_mode[i] && m_cnt[i] > 0) ? 1 : 0;
      m_cnt[i] = m_cnt[i] + inc - dec;
      if (m_cnt[i] > 15) m_cnt[i] = 15;
      if (dec == 1) np[i] = 1'b1;
`else
      inc = 0; dec = inc;
`endif
      if (done) ni[i] = 1'b0;
    end
    if (claim_req && w >= 0) begin
      np[w] = 1'b0;
      ni[w] = 1'b1;
    end
    m_pend = np;
    m_infl = ni;
    dl.push_front(int_in);
    void'(dl.pop_back());
  endfunction

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  task automatic check_model();
    check("pending_vec", 32'(pending_vec), 32'(m_pend));
    check("irq_out", 32'(irq_out), 32'(m_irq));
    check("claim_ack", 32'(claim_ack), 32'(m_ack));
    check("claim_id", 32'(claim_id), 32'(m_id));
  endtask

  task automatic step();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic cyc(input logic req, input logic cv,
                     input logic [IW-1:0] cid);
    claim_req = req;
    complete_valid = cv;
    complete_id = cid;
    step();
    check_model();
    claim_req = 1'b0;
    complete_valid = 1'b0;
    complete_id = '0;
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    int_in = '0;
    claim_req = 1'b0;
    complete_valid = 1'b0;
    complete_id = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    m_reset();
  endtask

  typedef struct packed {
    logic [N-1:0]  in;
    logic          req;
    logic          cv;
    logic [IW-1:0] cid;
    logic [N-1:0]  e_pend;
    logic          e_irq;
    logic          e_ack;
    logic [IW-1:0] e_id;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00100, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00100, 1'b1, 1'b0, 3'd0};
    tbl[4] = '{5'b00100, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b1, 1'b1, 3'd3};
    tbl[5] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{5'b00100, 1'b0, 1'b1, 3'd3, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[7] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00100, 1'b0, 1'b0, 3'd0};
    tbl[8] = '{5'b00100, 1'b0, 1'b0, 3'd0, 5'b00100, 1'b1, 1'b0, 3'd0};

    m_reset();
    #2;
    check("rst_pend", 32'(pending_vec), 32'h0);
    check("rst_irq", 32'(irq_out), 32'h0);
    check("rst_ack", 32'(claim_ack), 32'h0);
    check("rst_id", 32'(claim_id), 32'h0);

    // Level source 2 table
    edge_mode = '0;
    src_enable = '1;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      int_in = tbl[r].in;
      claim_req = tbl[r].req;
      complete_valid = tbl[r].cv;
      complete_id = tbl[r].cid;
      step();
      check($sformatf("tbl%0d_pend", r), 32'(pending_vec), 32'(tbl[r].e_pend));
      check($sformatf("tbl%0d_irq", r), 32'(irq_out), 32'(tbl[r].e_irq));
      check($sformatf("tbl%0d_ack", r), 32'(claim_ack), 32'(tbl[r].e_ack));
      check($sformatf("tbl%0d_id", r), 32'(claim_id), 32'(tbl[r].e_id));
    end
    claim_req = 1'b0;
    complete_valid = 1'b0;

    // Priority: sources 0 and 4, back-to-back claims
    do_reset();
    int_in = 5'b10001;
    repeat (4) cyc(1'b0, 1'b0, '0);
    check("prio_pend", 32'(pending_vec), 32'h11);
    cyc(1'b1, 1'b0, '0);
    check("prio_id1", 32'(claim_id), 32'd1);
    cyc(1'b1, 1'b0, '0);
    check("prio_id5", 32'(claim_id), 32'd5);
    cyc(1'b1, 1'b0, '0);
    check("prio_id0", 32'(claim_id), 32'd0);
    check("prio_ack0", 32'(claim_ack), 32'd1);
    check("prio_empty", 32'(pending_vec), 32'h0);

    // Edge source 1 with extra pulses while in flight
    do_reset();
    edge_mode = 5'b00010;
    int_in = 5'b00010;
    cyc(1'b0, 1'b0, '0);
    int_in = '0;
    repeat (3) cyc(1'b0, 1'b0, '0);
    check("edge_pend", 32'(pending_vec), 32'h02);
    cyc(1'b1, 1'b0, '0);
    check("edge_id", 32'(claim_id), 32'd2);
    repeat (3) begin
      int_in = 5'b00010;
      cyc(1'b0, 1'b0, '0);
      int_in = '0;
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
    end
    repeat (3) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 3'd2);
`ifdef INT_GATEWAY_EDGE_CNT_EN
    for (int r = 0; r < 3; r++) begin
      check($sformatf("cnt_repend%0d", r), 32'(pending_vec), 32'h02);
      cyc(1'b1, 1'b0, '0);
      check($sformatf("cnt_claim%0d", r), 32'(claim_id), 32'd2);
      cyc(1'b0, 1'b1, 3'd2);
    end
`endif
    repeat (3) begin
      check("edge_no_repend", 32'(pending_vec), 32'h0);
      cyc(1'b0, 1'b0, '0);
    end
    edge_mode = '0;

    // Disabled source 3 keeps pending but stays invisible
    do_reset();
    src_enable = 5'b10111;
    int_in = 5'b01000;
    repeat (4) cyc(1'b0, 1'b0, '0);
    check("dis_pend", 32'(pending_vec), 32'h08);
    check("dis_irq", 32'(irq_out), 32'h0);
    cyc(1'b1, 1'b0, '0);
    check("dis_ack", 32'(claim_ack), 32'd1);
    check("dis_id", 32'(claim_id), 32'd0);
    check("dis_keep", 32'(pending_vec), 32'h08);
    src_enable = '1;
    cyc(1'b0, 1'b0, '0);
    check("en_irq", 32'(irq_out), 32'h1);

    // Invalid completions leave state alone
    cyc(1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b1, 3'd7);
    cyc(1'b0, 1'b1, 3'd1);
    check("badc_pend", 32'(pending_vec), 32'h08);
    cyc(1'b1, 1'b0, '0);
    check("badc_id", 32'(claim_id), 32'd4);
    cyc(1'b0, 1'b1, 3'd1);
    cyc(1'b0, 1'b1, 3'd6);
    cyc(1'b0, 1'b0, '0);
    check("badc_infl", 32'(pending_vec), 32'h0);
    cyc(1'b0, 1'b1, 3'd4);
    cyc(1'b0, 1'b0, '0);
    check("goodc_repend", 32'(pending_vec), 32'h08);

    // Reset in the middle of a handshake
    do_reset();
    int_in = 5'b00101;
    repeat (4) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    check("mid_id", 32'(claim_id), 32'd1);
    claim_req = 1'b1;
    #2;
    rstnn = 1'b0;
    int_in = '0;
    #1;
    check("arst_pend", 32'(pending_vec), 32'h0);
    check("arst_irq", 32'(irq_out), 32'h0);
    check("arst_ack", 32'(claim_ack), 32'h0);
    check("arst_id", 32'(claim_id), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    claim_req = 1'b0;
    m_reset();
    repeat (3) begin
      cyc(1'b0, 1'b0, '0);
      check("arst_noack", 32'(claim_ack), 32'h0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [IW-1:0] cid;
      if (c % 300 == 0) edge_mode = N'($urandom);
      if (c % 25 == 0)
        src_enable = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 3) == 0) int_in = N'($urandom);
      if ($urandom_range(0, 9) < 6)
        cid = IW'($urandom_range(1, N));
      else
        cid = IW'($urandom_range(0, 7));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, cid);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
